ex_multicycle: RTL and testbench

Parametrised execute stage for the MIPS integer pipeline, sitting between ID and WB. It executes single-cycle ALU and shift ops with a registered result, and iterative multiply/divide ops (signed and unsigned) into internal HI/LO registers. It also handles HI/LO moves. A ready/valid handshake on the input stalls ID while a multi-cycle op is in flight.

---
 rtl/ex_multicycle_pkg.sv | 53 +++++
 rtl/ex_multicycle_if.sv | 37 +++
 rtl/ex_muldiv_unit.sv | 126 ++++++++++++
 rtl/ex_multicycle.sv | 121 ++++++++++++
 tb/tb_ex_multicycle.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_multicycle_pkg.sv
// Shared definitions for the execute stage: MIPS funct codes, FSM state
// encoding and the op-class decode used by the top and the mul/div unit.
package ex_multicycle_pkg;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} ex_state_t;

    typedef enum logic [2:0] {
        OPC_ALU, OPC_MTHI, OPC_MTLO, OPC_MULDIV, OPC_UNKNOWN
    } op_class_t;

    function automatic op_class_t op_class(input logic [5:0] f);
        op_class_t c;
        case (f)
            FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_ADDU, FUNCT_SUBU,
            FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR, FUNCT_SLT,
            FUNCT_SLTU, FUNCT_MFHI, FUNCT_MFLO:                   c = OPC_ALU;
            FUNCT_MTHI:                                           c = OPC_MTHI;
            FUNCT_MTLO:                                           c = OPC_MTLO;
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU:       c = OPC_MULDIV;
            default:                                              c = OPC_UNKNOWN;
        endcase
        return c;
    endfunction

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/ex_multicycle_if.sv
// ID-to-EX issue channel and EX result bundle.
interface ex_multicycle_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FUNCT_WIDTH    = 6,
    parameter int SHAMT_WIDTH    = 5
);
    // Handshake: an op transfers on a rising edge where in_valid & in_ready
    // and no flush; in_ready depends only on EX state, never on in_valid.
    // valid_out is a one-cycle pulse with no back-pressure from the consumer.
    logic                      in_valid;
    logic                      in_ready;
    logic [FUNCT_WIDTH-1:0]    funct;
    logic [SHAMT_WIDTH-1:0]    shamt;
    logic [DATA_WIDTH-1:0]     operand_1;
    logic [DATA_WIDTH-1:0]     operand_2;
    logic                      write_reg_en_in;
    logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in;
    logic                      valid_out;
    logic [DATA_WIDTH-1:0]     result_out;
    logic                      write_reg_en_out;
    logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out;

    modport master (
        output in_valid, funct, shamt, operand_1, operand_2,
               write_reg_en_in, write_reg_addr_in,
        input  in_ready, valid_out, result_out, write_reg_en_out,
               write_reg_addr_out
    );

    modport slave (
        input  in_valid, funct, shamt, operand_1, operand_2,
               write_reg_en_in, write_reg_addr_in,
        output in_ready, valid_out, result_out, write_reg_en_out,
               write_reg_addr_out
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle,
// with magnitude/sign handling and the final HI/LO sign correction.
module ex_muldiv_unit
    import ex_multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  logic                  is_div,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output ex_state_t             state_dbg
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    ex_state_t       state, state_next;
    logic [CW-1:0]   count;
    logic [W-1:0]    acc_hi, acc_lo, opnd, raw_a;
    logic            op_div, neg_res, neg_rem, div_zero;
    logic            a_neg, b_neg;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum;
    logic [W:0]      div_shift;
    logic [W+1:0]    div_diff;
    logic [2*W-1:0]  prod, prod_fix;
    logic [W-1:0]    quot, rem;

    assign a_neg = is_signed & op_a[W-1];
    assign b_neg = is_signed & op_b[W-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;

    // Multiply: acc_lo holds the multiplier and shifts out as product bits fill in.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    // Divide: acc_hi is the partial remainder, acc_lo the dividend/quotient.
    assign div_shift = {acc_hi, acc_lo[W-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = is_div ? ST_DIV : ST_MUL;
            ST_MUL, ST_DIV: if (count == CW'(1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            raw_a    <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            count    <= CW'(DATA_WIDTH);
            acc_hi   <= '0;
            acc_lo   <= is_div ? mag_a : mag_b;
            opnd     <= is_div ? mag_b : mag_a;
            raw_a    <= op_a;
            op_div   <= is_div;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= is_div & a_neg;
            div_zero <= (op_b == '0);
        end else if (state == ST_MUL) begin
            acc_hi <= mul_sum[W:1];
            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
            count  <= count - CW'(1);
        end else if (state == ST_DIV) begin
            if (!div_diff[W+1]) begin
                acc_hi <= div_diff[W-1:0];
                acc_lo <= {acc_lo[W-2:0], 1'b1};
            end else begin
                acc_hi <= div_shift[W-1:0];
                acc_lo <= {acc_lo[W-2:0], 1'b0};
            end
            count <= count - CW'(1);
        end
    end

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_res ? -prod : prod;
    assign quot     = neg_res ? -acc_lo : acc_lo;
    assign rem      = neg_rem ? -acc_hi : acc_hi;

    // Most-negative / -1 needs no special case: the unsigned magnitude
    // quotient already has the most-negative bit pattern and remainder 0.
    always_comb begin
        hi = prod_fix[2*W-1:W];
        lo = prod_fix[W-1:0];
        if (op_div) begin
            if (div_zero) begin
                lo = '1;
                hi = raw_a;
            end else begin
                lo = quot;
                hi = rem;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FIX) && !flush;
    assign state_dbg = state;

endmodule

// File: rtl/ex_multicycle.sv
// MIPS execute stage: registered single-cycle ALU/shift results, HI/LO
// registers and moves, and dispatch of mul/div to the iterative unit.
module ex_multicycle
    import ex_multicycle_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FUNCT_WIDTH    = 6,
    parameter int SHAMT_WIDTH    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    ex_multicycle_if.slave  bus,
    output ex_state_t       state_dbg
);
    localparam int W = DATA_WIDTH;

    logic [FUNCT_WIDTH-1:0]    funct_w;
    logic [SHAMT_WIDTH-1:0]    shamt_w;
    logic [5:0]                funct6;
    op_class_t                 cls;
    logic                      accept, md_start, md_busy, md_done;
    logic [W-1:0]              md_hi, md_lo, alu_result;
    logic [W-1:0]              hi_q, lo_q, result_q;
    logic                      valid_q, wen_q;
    logic [REG_ADDR_WIDTH-1:0] waddr_q, md_addr;

    assign funct_w = bus.funct;
    assign shamt_w = bus.shamt;
    assign funct6  = funct_w[5:0];
    assign cls     = op_class(funct6);

    assign bus.in_ready = !md_busy;
    assign accept       = bus.in_valid & bus.in_ready & !flush;
    assign md_start     = accept && (cls == OPC_MULDIV);

    always_comb begin
        alu_result = '0;
        case (funct6)
            FUNCT_SLL:  alu_result = bus.operand_2 << shamt_w;
            FUNCT_SRL:  alu_result = bus.operand_2 >> shamt_w;
            FUNCT_SRA:  alu_result = $unsigned($signed(bus.operand_2) >>> shamt_w);
            FUNCT_ADDU: alu_result = bus.operand_1 + bus.operand_2;
            FUNCT_SUBU: alu_result = bus.operand_1 - bus.operand_2;
            FUNCT_AND:  alu_result = bus.operand_1 & bus.operand_2;
            FUNCT_OR:   alu_result = bus.operand_1 | bus.operand_2;
            FUNCT_XOR:  alu_result = bus.operand_1 ^ bus.operand_2;
            FUNCT_NOR:  alu_result = ~(bus.operand_1 | bus.operand_2);
            FUNCT_SLT:  alu_result = {{(W-1){1'b0}},
                                      $signed(bus.operand_1) < $signed(bus.operand_2)};
            FUNCT_SLTU: alu_result = {{(W-1){1'b0}}, bus.operand_1 < bus.operand_2};
            FUNCT_MFHI: alu_result = hi_q;
            FUNCT_MFLO: alu_result = lo_q;
            default:    alu_result = '0;
        endcase
    end

    ex_muldiv_unit #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (md_start),
        .is_div    (is_div_op(funct6)),
        .is_signed (is_signed_op(funct6)),
        .op_a      (bus.operand_1),
        .op_b      (bus.operand_2),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo),
        .state_dbg (state_dbg)
    );

    // Ops that only touch HI/LO still issue a bundle, with the GPR write off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            md_addr  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (md_done) begin
                hi_q     <= md_hi;
                lo_q     <= md_lo;
                valid_q  <= 1'b1;
                result_q <= '0;
                wen_q    <= 1'b0;
                waddr_q  <= md_addr;
            end else if (accept) begin
                case (cls)
                    OPC_MULDIV: md_addr <= bus.write_reg_addr_in;
                    OPC_MTHI, OPC_MTLO: begin
                        if (cls == OPC_MTHI) hi_q <= bus.operand_1;
                        else                 lo_q <= bus.operand_1;
                        valid_q  <= 1'b1;
                        result_q <= '0;
                        wen_q    <= 1'b0;
                        waddr_q  <= bus.write_reg_addr_in;
                    end
                    default: begin
                        valid_q  <= 1'b1;
                        result_q <= alu_result;
                        wen_q    <= bus.write_reg_en_in;
                        waddr_q  <= bus.write_reg_addr_in;
                    end
                endcase
            end
        end
    end

    assign bus.valid_out          = valid_q;
    assign bus.result_out         = result_q;
    assign bus.write_reg_en_out   = wen_q;
    assign bus.write_reg_addr_out = waddr_q;

endmodule

// File: tb/tb_ex_multicycle.sv
// Directed bench for ex_multicycle: expected bundles are queued at issue and
// a negedge monitor pops and compares each valid_out pulse.
module tb_ex_multicycle;
  import ex_multicycle_pkg::*;

  localparam int W  = 32;
  localparam int RW = 5;
  localparam int BW = 1 + RW + W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  ex_state_t state_dbg;

  ex_multicycle_if #(.DATA_WIDTH(W), .REG_ADDR_WIDTH(RW), .FUNCT_WIDTH(6), .SHAMT_WIDTH(5)) bus ();

  ex_multicycle #(.DATA_WIDTH(W), .REG_ADDR_WIDTH(RW), .FUNCT_WIDTH(6), .SHAMT_WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input logic en, input logic [RW-1:0] addr, input logic [W-1:0] res);
    return {en, addr, res};
  endfunction

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [BW-1:0] got;
    logic [BW-1:0] e;
    if (rst && bus.valid_out) begin
      got = {bus.write_reg_en_out, bus.write_reg_addr_out, bus.result_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got %h with nothing expected", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL bundle: got en/addr/res %h expected %h", got, e);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [4:0] sh, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic en, input logic [RW-1:0] addr,
                       input bit push, input logic [BW-1:0] exp);
    int waits = 0;
    bus.funct = f;
    bus.shamt = sh;
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.write_reg_en_in = en;
    bus.write_reg_addr_in = addr;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    check("issue_ready", {63'd0, bus.in_ready}, 64'd1);
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic alu(input logic [5:0] f, input logic [4:0] sh, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [RW-1:0] addr, input logic [W-1:0] res);
    issue(f, sh, a, b, 1'b1, addr, 1'b1, mk(1'b1, addr, res));
  endtask

  task automatic muldiv(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] addr);
    int n = 0;
    issue(f, 5'd0, a, b, 1'b1, addr, 1'b1, mk(1'b0, addr, '0));
    while (!bus.in_ready && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_cycles", 64'(n), 64'(W + 1));
    check("muldiv_valid", {63'd0, bus.valid_out}, 64'd1);
  endtask

  task automatic read_hilo(input logic [W-1:0] hi, input logic [W-1:0] lo);
    alu(FUNCT_MFLO, 5'd0, '0, '0, 5'd12, lo);
    alu(FUNCT_MFHI, 5'd0, '0, '0, 5'd13, hi);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.funct = '0;
    bus.shamt = '0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.write_reg_en_in = 1'b0;
    bus.write_reg_addr_in = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_valid", {63'd0, bus.valid_out}, 64'd0);
    check("rst_result", {32'd0, bus.result_out}, 64'd0);
    check("rst_wen", {63'd0, bus.write_reg_en_out}, 64'd0);
    check("rst_waddr", {59'd0, bus.write_reg_addr_out}, 64'd0);
    check("rst_state", {62'd0, state_dbg}, {62'd0, ST_IDLE});
    rst = 1'b1;
    @(posedge clk); #1;

    // OR with one-cycle valid pulse
    alu(FUNCT_OR, 5'd0, 32'h0000_F0F0, 32'h0F0F_0000, 5'd3, 32'h0F0F_F0F0);
    check("or_valid_pulse", {63'd0, bus.valid_out}, 64'd1);
    @(posedge clk); #1;
    check("or_valid_drop", {63'd0, bus.valid_out}, 64'd0);

    // Back-to-back single-cycle ops
    alu(FUNCT_ADDU, 5'd0, 32'hFFFF_FFFF, 32'h1, 5'd5, 32'h0);
    alu(FUNCT_SUBU, 5'd0, 32'h0, 32'h1, 5'd6, 32'hFFFF_FFFF);
    alu(FUNCT_AND, 5'd0, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd7, 32'h3030_3030);
    alu(FUNCT_XOR, 5'd0, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd8, 32'hCCCC_CCCC);
    alu(FUNCT_NOR, 5'd0, 32'h0, 32'h0, 5'd9, 32'hFFFF_FFFF);
    alu(FUNCT_SLT, 5'd0, 32'hFFFF_FFFF, 32'h1, 5'd10, 32'h1);
    alu(FUNCT_SLTU, 5'd0, 32'hFFFF_FFFF, 32'h1, 5'd11, 32'h0);
    alu(FUNCT_SLL, 5'd31, 32'h0, 32'h1, 5'd12, 32'h8000_0000);
    alu(FUNCT_SRL, 5'd4, 32'h0, 32'h8000_0000, 5'd13, 32'h0800_0000);
    alu(FUNCT_SRA, 5'd4, 32'h0, 32'h8000_0000, 5'd14, 32'hF800_0000);
    alu(6'h3F, 5'd0, 32'h1234, 32'h5678, 5'd9, 32'h0);

    // HI/LO moves, back-to-back
    issue(FUNCT_MTHI, 5'd0, 32'h1234, 32'h0, 1'b1, 5'd2, 1'b1, mk(1'b0, 5'd2, '0));
    alu(FUNCT_MFHI, 5'd0, '0, '0, 5'd4, 32'h1234);
    issue(FUNCT_MTLO, 5'd0, 32'h5678, 32'h0, 1'b1, 5'd2, 1'b1, mk(1'b0, 5'd2, '0));
    alu(FUNCT_MFLO, 5'd0, '0, '0, 5'd4, 32'h5678);

    // Multiply / divide
    muldiv(FUNCT_MULT, 32'hFFFF_FFFE, 32'h3, 5'd20);
    read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA);
    muldiv(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21);
    read_hilo(32'hFFFF_FFFE, 32'h0000_0001);
    muldiv(FUNCT_DIV, 32'hFFFF_FFF9, 32'h2, 5'd22);
    read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    muldiv(FUNCT_DIV, 32'h7, 32'hFFFF_FFFE, 5'd23);
    read_hilo(32'h0000_0001, 32'hFFFF_FFFD);
    muldiv(FUNCT_DIVU, 32'h7, 32'h0, 5'd24);
    read_hilo(32'h0000_0007, 32'hFFFF_FFFF);
    muldiv(FUNCT_DIV, 32'hFFFF_FFF9, 32'h0, 5'd25);
    read_hilo(32'hFFFF_FFF9, 32'hFFFF_FFFF);
    muldiv(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd26);
    read_hilo(32'h0000_0000, 32'h8000_0000);
    muldiv(FUNCT_DIVU, 32'd100, 32'd7, 5'd27);
    read_hilo(32'h0000_0002, 32'h0000_000E);

    // Flush at busy cycle 10 of a DIVU: no bundle, HI/LO untouched
    issue(FUNCT_DIVU, 5'd0, 32'd50, 32'd3, 1'b1, 5'd28, 1'b0, '0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("flush_state", {62'd0, state_dbg}, {62'd0, ST_IDLE});
    check("flush_valid", {63'd0, bus.valid_out}, 64'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    read_hilo(32'h0000_0002, 32'h0000_000E);

    // Flush together with in_valid: nothing accepted
    bus.funct = FUNCT_ADDU;
    bus.operand_1 = 32'h1;
    bus.operand_2 = 32'h1;
    bus.write_reg_en_in = 1'b1;
    bus.write_reg_addr_in = 5'd1;
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_no_accept", {63'd0, bus.valid_out}, 64'd0);

    // Asynchronous reset in the middle of a MULT
    issue(FUNCT_MULT, 5'd0, 32'h1234_5678, 32'h9, 1'b1, 5'd30, 1'b0, '0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", {63'd0, bus.valid_out}, 64'd0);
    check("arst_result", {32'd0, bus.result_out}, 64'd0);
    check("arst_wen", {63'd0, bus.write_reg_en_out}, 64'd0);
    check("arst_waddr", {59'd0, bus.write_reg_addr_out}, 64'd0);
    check("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("arst_state", {62'd0, state_dbg}, {62'd0, ST_IDLE});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    read_hilo(32'h0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
